core_frame_receiver: RTL and testbench
======================================

# core_frame_receiver

Per-core receiving end of the task-scheduler instruction-frame protocol. It captures the `Insn_Load_Counter`-indexed parts of an instruction frame into a local instruction buffer and presents the R0 initial value. It also drives the core's `Ready` handshake back to the scheduler. One instance sits in each core, between the scheduler bus slice for that core and the core's fetch/execute pipeline.

## Interface
Parameters:
- `INSN_BUS_WIDTH`, default 32: width of one frame part / buffer word.
- `INSN_LOAD_TIME`, default 8: parts per instruction frame; buffer depth.
- `CNT_WIDTH`, default 3: width of the load counter, equal to clog2(`INSN_LOAD_TIME`).
- `REG_WIDTH`, default 8: width of the R0 init value.

Ports:
- `clk`, in, 1: the single clock.
- `reset`, in, 1: asynchronous, active-high.
- `Start`, in, 1: this core's bit of the scheduler Start vector; a frame part is valid this cycle.
- `Insn_Load_Counter`, in, `CNT_WIDTH`: index of the part on `Insn_Data`.
- `Insn_Data`, in, `INSN_BUS_WIDTH`: frame part.
- `Init_R0_En`, in, 1: this core's bit of `Init_R0_Vect`.
- `Init_R0_Val`, in, `REG_WIDTH`: this core's slice of `Init_R0`.
- `Ready`, out, 1: core idle and able to accept a frame.
- `exec_go`, out, 1: one-cycle pulse; the buffered frame is complete and execution starts.
- `r0_we`, out, 1: R0 write strobe, coincident with `exec_go`.
- `r0_wdata`, out, `REG_WIDTH`: R0 write value.
- `exec_done`, in, 1: pulse from the pipeline; the frame has finished executing.
- `fetch_addr`, in, `CNT_WIDTH`: pipeline read address.
- `fetch_insn`, out, `INSN_BUS_WIDTH`: registered read data.
- `load_err`, out, 1: sticky protocol-violation flag (see Configuration).

## Operation
- FSM states are IDLE, LOAD, ARM and EXEC.
- **IDLE** (`Ready`=1):
  - `Start` writes `Insn_Data` to `buf[Insn_Load_Counter]`.
  - If the counter equals `INSN_LOAD_TIME`-1, go to ARM. Otherwise go to LOAD.
- **LOAD** (`Ready`=1):
  - Each `Start` cycle writes `buf[Insn_Load_Counter]`.
  - A write with counter equal to `INSN_LOAD_TIME`-1 moves to ARM.
  - `Start` low means hold in LOAD and write nothing.
- **ARM** (`Ready`=0): always moves to EXEC next cycle.
  - `exec_go`=1 for exactly this cycle.
  - `r0_we`=`Init_R0_En` and `r0_wdata`=`Init_R0_Val`, both sampled in this cycle.
  - R0 is re-initialised on every frame for which `Init_R0_En` is high.
- **EXEC** (`Ready`=0):
  - `exec_done` moves to IDLE.
  - `Start` is ignored and nothing is written.
- `exec_done` outside EXEC is ignored, including in the ARM cycle.
- `Ready` is a registered output. It falls on the same edge that captures the final part, so the scheduler never sees the core ready in the cycle after the last part.
- Fetch reads are read-before-write: a read of an address written in the same cycle returns the old word.

## Timing
- Reset values:
  - `Ready`=1.
  - `exec_go`, `r0_we`, `r0_wdata`, `fetch_insn` and `load_err` are all 0.
  - FSM goes to IDLE.
  - Buffer contents are not reset.
- The final part is captured at edge N. At N+1, `Ready`=0 and `exec_go`=1. At N+2 the FSM is in EXEC.
- Minimum frame turnaround is `INSN_LOAD_TIME` + 3 cycles: the load cycles, ARM, one EXEC cycle with `exec_done`, then IDLE with `Ready` rising.
- `fetch_insn` has a latency of 1 cycle from `fetch_addr`.
- When `INSN_LOAD_TIME`=1, IDLE goes directly to ARM on any `Start`.
- `reset` asserted mid-LOAD or mid-EXEC returns the FSM to IDLE asynchronously with `Ready`=1. Partially loaded words stay in the buffer; they are stale but harmless.

## Configuration
- `CORE_FRAME_CHECK_EN` defined:
  - An internal expected-index counter resets to 0 on entry to IDLE and advances on each accepted `Start`.
  - `load_err` sets and stays set until `reset` when either:
    - `Start` arrives with `Insn_Load_Counter` not equal to the expected index, or
    - `Start` arrives in ARM or EXEC.
  - Data is still written at `Insn_Load_Counter`, and FSM behaviour is unchanged.
- `CORE_FRAME_CHECK_EN` undefined: there is no expected-index counter and `load_err` is tied to 0.

## Structure
- Shared package / define header holds:
  - state encoding (IDLE=0, LOAD=1, ARM=2, EXEC=3);
  - default `INSN_LOAD_TIME`, `INSN_BUS_WIDTH` and `REG_WIDTH`, identical to the scheduler's range defines.
- Sub-module `core_insn_buf`: `INSN_LOAD_TIME` x `INSN_BUS_WIDTH` storage with one write port and one registered read port, read-before-write.

## Test plan
All scenarios use `INSN_LOAD_TIME`=8 and a width of 32.
- **Reset:** assert `reset` asynchronously mid-cycle -> `Ready`=1 and `exec_go`=0 immediately; the FSM is in IDLE.
- **Full frame load:** `Start` with counter 0..7 and data 0xA0..0xA7, `Init_R0_En`=1, `Init_R0_Val`=0x5C.
  - The cycle after counter 7: `Ready`=0, `exec_go`=1, `r0_we`=1, `r0_wdata`=0x5C.
  - Fetch addresses 0..7 return 0xA0..0xA7 one cycle later.
- **Load stall:** `Start` is dropped for 3 cycles after counter 3 and the counter is held -> the FSM stays in LOAD with `Ready`=1. Resuming at counter 4 completes normally.
- **Exec handshake:**
  - `exec_done` in the ARM cycle is ignored.
  - `exec_done` 5 cycles into EXEC gives `Ready`=1 the next cycle.
  - A second frame (0xB0..0xB7) then loads and overwrites the buffer.
- **Protocol violation with `CORE_FRAME_CHECK_EN`:**
  - A counter sequence 0,1,3 gives `load_err`=1 one cycle after counter 3, and the flag stays set.
  - `Start` during EXEC is ignored with no buffer write; `load_err`=1.
- **Reset mid-EXEC:** reset in EXEC -> `Ready`=1 and the FSM is in IDLE. A following frame loads correctly and `exec_go` pulses exactly once.

Source files
------------

// File: rtl/core_frame_receiver_pkg.sv
// Shared definitions for the per-core instruction-frame receiver: FSM encoding
// and default frame geometry, matching the scheduler's range defaults.
package core_frame_receiver_pkg;

  localparam int DEF_INSN_BUS_WIDTH = 32;
  localparam int DEF_INSN_LOAD_TIME = 8;
  localparam int DEF_CNT_WIDTH      = 3;
  localparam int DEF_REG_WIDTH      = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ARM  = 2'd2,
    ST_EXEC = 2'd3
  } frame_state_t;

  // Ready is asserted while the core can still take frame parts.
  function automatic logic state_is_ready(input frame_state_t st);
    return (st == ST_IDLE) || (st == ST_LOAD);
  endfunction

endpackage

// File: rtl/core_frame_receiver_insn_buf.sv
// Local instruction buffer: one write port, one registered read port.
// A read of the address written in the same cycle returns the previous word.
module core_insn_buf #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_reg;

  // Storage carries no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_reg <= '0;
    end else begin
      rdata_reg <= mem[raddr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/core_frame_receiver.sv
// Per-core receiver of scheduler instruction frames: buffers frame parts, arms
// execution and drives Ready. Optional index checking under CORE_FRAME_CHECK_EN.
module core_frame_receiver
  import core_frame_receiver_pkg::*;
#(
  parameter int INSN_BUS_WIDTH = DEF_INSN_BUS_WIDTH,
  parameter int INSN_LOAD_TIME = DEF_INSN_LOAD_TIME,
  parameter int CNT_WIDTH      = DEF_CNT_WIDTH,
  parameter int REG_WIDTH      = DEF_REG_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      Start,
  input  logic [CNT_WIDTH-1:0]      Insn_Load_Counter,
  input  logic [INSN_BUS_WIDTH-1:0] Insn_Data,
  input  logic                      Init_R0_En,
  input  logic [REG_WIDTH-1:0]      Init_R0_Val,
  output logic                      Ready,
  output logic                      exec_go,
  output logic                      r0_we,
  output logic [REG_WIDTH-1:0]      r0_wdata,
  input  logic                      exec_done,
  input  logic [CNT_WIDTH-1:0]      fetch_addr,
  output logic [INSN_BUS_WIDTH-1:0] fetch_insn,
  output logic                      load_err
);

  frame_state_t state_reg, state_next;
  logic         ready_reg, ready_next;
  logic         accept;
  logic         last_part;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      ready_reg <= 1'b1;
    end else begin
      state_reg <= state_next;
      ready_reg <= ready_next;
    end
  end

  // A single-part frame completes on any Start regardless of the index.
  always_comb begin
    accept    = Start && state_is_ready(state_reg);
    last_part = (INSN_LOAD_TIME == 1) ||
                (Insn_Load_Counter == CNT_WIDTH'(INSN_LOAD_TIME - 1));
  end

  // Ready is derived from the next state so it drops on the final-part edge.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (Start) state_next = last_part ? ST_ARM : ST_LOAD;
      ST_LOAD: if (Start && last_part) state_next = ST_ARM;
      ST_ARM:  state_next = ST_EXEC;
      ST_EXEC: if (exec_done) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    ready_next = state_is_ready(state_next);
  end

  always_comb begin
    exec_go  = 1'b0;
    r0_we    = 1'b0;
    r0_wdata = '0;
    if (state_reg == ST_ARM) begin
      exec_go  = 1'b1;
      r0_we    = Init_R0_En;
      r0_wdata = Init_R0_Val;
    end
  end

  assign Ready = ready_reg;

  core_insn_buf #(
    .DEPTH (INSN_LOAD_TIME),
    .WIDTH (INSN_BUS_WIDTH),
    .AW    (CNT_WIDTH)
  ) u_insn_buf (
    .clk   (clk),
    .reset (reset),
    .we    (accept),
    .waddr (Insn_Load_Counter),
    .wdata (Insn_Data),
    .raddr (fetch_addr),
    .rdata (fetch_insn)
  );

`ifdef CORE_FRAME_CHECK_EN
  logic [CNT_WIDTH-1:0] exp_idx_reg;
  logic                 load_err_reg;
  logic                 idx_bad;
  logic                 late_start;

  always_comb begin
    idx_bad    = accept && (Insn_Load_Counter != exp_idx_reg);
    late_start = Start && ((state_reg == ST_ARM) || (state_reg == ST_EXEC));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_idx_reg  <= '0;
      load_err_reg <= 1'b0;
    end else begin
      if ((state_next == ST_IDLE) && (state_reg != ST_IDLE)) begin
        exp_idx_reg <= '0;
      end else if (accept) begin
        exp_idx_reg <= exp_idx_reg + CNT_WIDTH'(1);
      end
      if (idx_bad || late_start) begin
        load_err_reg <= 1'b1;
      end
    end
  end

  assign load_err = load_err_reg;
`else
  assign load_err = 1'b0;
`endif

endmodule

// File: tb/tb_core_frame_receiver.sv
// Self-checking bench for core_frame_receiver; fetch results go through a scoreboard queue.
module tb_core_frame_receiver;

  logic        clk;
  logic        reset;
  logic        Start;
  logic [2:0]  Insn_Load_Counter;
  logic [31:0] Insn_Data;
  logic        Init_R0_En;
  logic [7:0]  Init_R0_Val;
  logic        Ready;
  logic        exec_go;
  logic        r0_we;
  logic [7:0]  r0_wdata;
  logic        exec_done;
  logic [2:0]  fetch_addr;
  logic [31:0] fetch_insn;
  logic        load_err;

  int          checks;
  int          errors;
  logic [31:0] exp_q [$];
  logic [31:0] exp_w;

  core_frame_receiver #(
    .INSN_BUS_WIDTH (32),
    .INSN_LOAD_TIME (8),
    .CNT_WIDTH      (3),
    .REG_WIDTH      (8)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .Start             (Start),
    .Insn_Load_Counter (Insn_Load_Counter),
    .Insn_Data         (Insn_Data),
    .Init_R0_En        (Init_R0_En),
    .Init_R0_Val       (Init_R0_Val),
    .Ready             (Ready),
    .exec_go           (exec_go),
    .r0_we             (r0_we),
    .r0_wdata          (r0_wdata),
    .exec_done         (exec_done),
    .fetch_addr        (fetch_addr),
    .fetch_insn        (fetch_insn),
    .load_err          (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_part(input int idx, input logic [31:0] d);
    Start = 1'b1;
    Insn_Load_Counter = 3'(idx);
    Insn_Data = d;
    step();
    Start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    checks++; if (Ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", Ready); end
    checks++; if (exec_go !== 1'b0) begin errors++; $display("FAIL reset_exec_go: got %b expected 0", exec_go); end
    checks++; if (r0_we !== 1'b0 || r0_wdata !== 8'h00) begin errors++; $display("FAIL reset_r0: got we=%b data=%h expected 0/00", r0_we, r0_wdata); end
    checks++; if (fetch_insn !== 32'h0) begin errors++; $display("FAIL reset_fetch: got %h expected 00000000", fetch_insn); end
    checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL reset_load_err: got %b expected 0", load_err); end
    #4 reset = 1'b0;
    step();
    send_part(0, 32'h1);
    send_part(1, 32'h2);
    checks++; if (Ready !== 1'b1) begin errors++; $display("FAIL midload_ready: got %b expected 1", Ready); end
    #2 reset = 1'b1;
    #1;
    checks++; if (Ready !== 1'b1 || exec_go !== 1'b0) begin errors++; $display("FAIL midload_reset: got ready=%b go=%b expected 1/0", Ready, exec_go); end
    #2 reset = 1'b0;
    step();
    for (int i = 0; i < 8; i++) send_part(i, 32'h100 + i);
    checks++; if (exec_go !== 1'b1) begin errors++; $display("FAIL arm_before_reset: got go=%b expected 1", exec_go); end
    #2 reset = 1'b1;
    #1;
    checks++; if (Ready !== 1'b1 || exec_go !== 1'b0) begin errors++; $display("FAIL arm_async_reset: got ready=%b go=%b expected 1/0", Ready, exec_go); end
    #2 reset = 1'b0;
    step();
    checks++; if (Ready !== 1'b1 || exec_go !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got ready=%b go=%b expected 1/0", Ready, exec_go); end
    $display("reset: async reset in IDLE, LOAD and ARM done");
  endtask

  task automatic test_full_frame();
    Init_R0_En = 1'b1;
    Init_R0_Val = 8'h5C;
    for (int i = 0; i < 8; i++) begin
      checks++; if (Ready !== 1'b1) begin errors++; $display("FAIL full_ready_part%0d: got %b expected 1", i, Ready); end
      send_part(i, 32'hA0 + i);
    end
    checks++; if (Ready !== 1'b0 || exec_go !== 1'b1) begin errors++; $display("FAIL full_arm: got ready=%b go=%b expected 0/1", Ready, exec_go); end
    checks++; if (r0_we !== 1'b1 || r0_wdata !== 8'h5C) begin errors++; $display("FAIL full_r0: got we=%b data=%h expected 1/5c", r0_we, r0_wdata); end
    step();
    checks++; if (Ready !== 1'b0 || exec_go !== 1'b0 || r0_we !== 1'b0) begin errors++; $display("FAIL full_exec: got ready=%b go=%b we=%b expected 0/0/0", Ready, exec_go, r0_we); end
    for (int a = 0; a < 8; a++) begin
      fetch_addr = 3'(a);
      exp_q.push_back(32'hA0 + a);
      step();
      exp_w = exp_q.pop_front();
      checks++; if (fetch_insn !== exp_w) begin errors++; $display("FAIL full_fetch%0d: got %h expected %h", a, fetch_insn, exp_w); end
      else $display("full frame fetch addr %0d data %h", a, fetch_insn);
    end
    exec_done = 1'b1;
    step();
    exec_done = 1'b0;
    checks++; if (Ready !== 1'b1) begin errors++; $display("FAIL full_done_ready: got %b expected 1", Ready); end
  endtask

  task automatic test_load_stall();
    Init_R0_En = 1'b0;
    Init_R0_Val = 8'h33;
    for (int i = 0; i < 4; i++) send_part(i, 32'hC0 + i);
    for (int s = 0; s < 3; s++) begin
      Insn_Load_Counter = 3'd3;
      Insn_Data = 32'hDEAD;
      step();
      checks++; if (Ready !== 1'b1 || exec_go !== 1'b0) begin errors++; $display("FAIL stall%0d: got ready=%b go=%b expected 1/0", s, Ready, exec_go); end
    end
    for (int i = 4; i < 8; i++) send_part(i, 32'hC0 + i);
    checks++; if (Ready !== 1'b0 || exec_go !== 1'b1 || r0_we !== 1'b0) begin errors++; $display("FAIL stall_arm: got ready=%b go=%b we=%b expected 0/1/0", Ready, exec_go, r0_we); end
    step();
    for (int a = 0; a < 8; a++) begin
      fetch_addr = 3'(a);
      exp_q.push_back(32'hC0 + a);
      step();
      exp_w = exp_q.pop_front();
      checks++; if (fetch_insn !== exp_w) begin errors++; $display("FAIL stall_fetch%0d: got %h expected %h", a, fetch_insn, exp_w); end
      else $display("stall frame fetch addr %0d data %h", a, fetch_insn);
    end
    exec_done = 1'b1;
    step();
    exec_done = 1'b0;
    checks++; if (Ready !== 1'b1) begin errors++; $display("FAIL stall_done_ready: got %b expected 1", Ready); end
  endtask

  task automatic test_exec_handshake();
    Init_R0_En = 1'b1;
    Init_R0_Val = 8'h77;
    for (int i = 0; i < 8; i++) send_part(i, 32'hD0 + i);
    checks++; if (exec_go !== 1'b1 || r0_wdata !== 8'h77) begin errors++; $display("FAIL hs_arm: got go=%b data=%h expected 1/77", exec_go, r0_wdata); end
    exec_done = 1'b1;
    step();
    exec_done = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks++; if (Ready !== 1'b0) begin errors++; $display("FAIL hs_exec_cycle%0d: got ready=%b expected 0", c, Ready); end
      step();
    end
    exec_done = 1'b1;
    step();
    exec_done = 1'b0;
    checks++; if (Ready !== 1'b1) begin errors++; $display("FAIL hs_done_ready: got %b expected 1", Ready); end
    // Second frame: reading the address being written returns the old word.
    for (int i = 0; i < 8; i++) begin
      fetch_addr = 3'(i);
      exp_q.push_back(32'hD0 + i);
      send_part(i, 32'hB0 + i);
      exp_w = exp_q.pop_front();
      checks++; if (fetch_insn !== exp_w) begin errors++; $display("FAIL hs_rbw%0d: got %h expected %h", i, fetch_insn, exp_w); end
      else $display("read-before-write addr %0d data %h", i, fetch_insn);
    end
    checks++; if (exec_go !== 1'b1) begin errors++; $display("FAIL hs_second_arm: got %b expected 1", exec_go); end
    step();
    for (int a = 0; a < 8; a++) begin
      fetch_addr = 3'(a);
      exp_q.push_back(32'hB0 + a);
      step();
      exp_w = exp_q.pop_front();
      checks++; if (fetch_insn !== exp_w) begin errors++; $display("FAIL hs_fetch%0d: got %h expected %h", a, fetch_insn, exp_w); end
      else $display("second frame fetch addr %0d data %h", a, fetch_insn);
    end
    exec_done = 1'b1;
    step();
    exec_done = 1'b0;
  endtask

  task automatic test_protocol();
    logic err_exp;
`ifdef CORE_FRAME_CHECK_EN
    err_exp = 1'b1;
`else
    err_exp = 1'b0;
`endif
    send_part(0, 32'hE0);
    send_part(1, 32'hE1);
    checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL proto_in_order: got %b expected 0", load_err); end
    send_part(3, 32'hE3);
    checks++; if (load_err !== err_exp) begin errors++; $display("FAIL proto_skip: got %b expected %b", load_err, err_exp); end
    for (int i = 4; i < 8; i++) send_part(i, 32'hE0 + i);
    checks++; if (exec_go !== 1'b1) begin errors++; $display("FAIL proto_arm: got %b expected 1", exec_go); end
    step();
    send_part(0, 32'hFFFF_FFFF);
    checks++; if (Ready !== 1'b0 || load_err !== err_exp) begin errors++; $display("FAIL proto_exec_start: got ready=%b err=%b expected 0/%b", Ready, load_err, err_exp); end
    fetch_addr = 3'd0;
    exp_q.push_back(32'hE0);
    step();
    exp_w = exp_q.pop_front();
    checks++; if (fetch_insn !== exp_w) begin errors++; $display("FAIL proto_no_write: got %h expected %h", fetch_insn, exp_w); end
    else $display("protocol fetch addr 0 data %h", fetch_insn);
    exec_done = 1'b1;
    step();
    exec_done = 1'b0;
    checks++; if (load_err !== err_exp || Ready !== 1'b1) begin errors++; $display("FAIL proto_sticky: got err=%b ready=%b expected %b/1", load_err, Ready, err_exp); end
    #2 reset = 1'b1;
    #1;
    checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL proto_clear: got %b expected 0", load_err); end
    #2 reset = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_exec();
    int go_count;
    Init_R0_En = 1'b0;
    for (int i = 0; i < 8; i++) send_part(i, 32'hF0 + i);
    step();
    step();
    checks++; if (Ready !== 1'b0) begin errors++; $display("FAIL rme_in_exec: got %b expected 0", Ready); end
    #2 reset = 1'b1;
    #1;
    checks++; if (Ready !== 1'b1 || exec_go !== 1'b0) begin errors++; $display("FAIL rme_reset: got ready=%b go=%b expected 1/0", Ready, exec_go); end
    #2 reset = 1'b0;
    step();
    go_count = 0;
    for (int i = 0; i < 8; i++) begin
      send_part(i, 32'h10 + i);
      if (exec_go === 1'b1) go_count++;
    end
    for (int c = 0; c < 4; c++) begin
      step();
      if (exec_go === 1'b1) go_count++;
    end
    checks++; if (go_count != 1) begin errors++; $display("FAIL rme_go_once: got %0d pulses expected 1", go_count); end
    for (int a = 0; a < 8; a++) begin
      fetch_addr = 3'(a);
      exp_q.push_back(32'h10 + a);
      step();
      exp_w = exp_q.pop_front();
      checks++; if (fetch_insn !== exp_w) begin errors++; $display("FAIL rme_fetch%0d: got %h expected %h", a, fetch_insn, exp_w); end
      else $display("post-reset frame fetch addr %0d data %h", a, fetch_insn);
    end
    exec_done = 1'b1;
    step();
    exec_done = 1'b0;
    checks++; if (Ready !== 1'b1) begin errors++; $display("FAIL rme_done_ready: got %b expected 1", Ready); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    Start = 1'b0;
    Insn_Load_Counter = 3'd0;
    Insn_Data = 32'h0;
    Init_R0_En = 1'b0;
    Init_R0_Val = 8'h00;
    exec_done = 1'b0;
    fetch_addr = 3'd0;
    test_reset();
    test_full_frame();
    test_load_stall();
    test_exec_handshake();
    test_protocol();
    test_reset_mid_exec();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
